scalar_mult_ctrl: RTL and testbench

//   Sequences one shared EC point unit (affine add/double over GF(p)) to compute Q = k*P.

---
 rtl/scalar_mult_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_scalar_mult_ctrl.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/scalar_mult_ctrl.sv
// scalar_mult_ctrl: left-to-right double-and-add sequencer computing Q = k*P
// by driving one shared affine EC point unit (add/double over GF(p)).
// Leading zero bits of k are scanned one per cycle without issuing any
// operation. The point at infinity is tracked locally in qinf and is never
// handed to the point unit as operand data.
// The accumulator Q lives directly in op_x1/op_y1 and the base point P in
// op_x2/op_y2. Both change only while no operation is in flight, so the
// operands stay stable from op_start until op_done.
// op_p forwards the field prime latched at start to the point unit.
// Optional macro SCALAR_CONST_TIME_EN: every 0 bit after the leading 1 still
// issues an add whose result is discarded, so each bit costs 1 dbl + 1 add.
//
// state      | meaning
// -----------+----------------------------------------------------------
// S_IDLE     | waiting for start; results held
// S_SCAN     | skip leading zero bits of k, one bit per cycle
// S_NEXT     | step to the next lower bit, or finish after bit 0
// S_DBL      | Q = 2Q (skipped while Q is infinity)
// S_DBL_WAIT | waiting for the doubling result
// S_BITCHK   | current bit set: Q = Q + P (or Q = P when Q is infinity)
// S_ADD_WAIT | waiting for the add result
// S_DONE     | publish Q, pulse done
module scalar_mult_ctrl #(
  parameter int n  = 231,
  parameter int KW = 231
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [KW-1:0] k,
  input  logic [n-1:0]  p,
  input  logic [n-1:0]  xp,
  input  logic [n-1:0]  yp,
  output logic          op_start,
  output logic          op_dbl,
  output logic [n-1:0]  op_p,
  output logic [n-1:0]  op_x1,
  output logic [n-1:0]  op_y1,
  output logic [n-1:0]  op_x2,
  output logic [n-1:0]  op_y2,
  input  logic          op_done,
  input  logic [n-1:0]  op_x3,
  input  logic [n-1:0]  op_y3,
  input  logic          op_inf,
  output logic [n-1:0]  x_out,
  output logic [n-1:0]  y_out,
  output logic          result_inf,
  output logic          busy,
  output logic          done
);

  localparam int IW = (KW > 1) ? $clog2(KW) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_SCAN, S_NEXT, S_DBL, S_DBL_WAIT, S_BITCHK, S_ADD_WAIT, S_DONE
  } state_t;

  state_t        state;
  logic [KW-1:0] k_r;
  logic [IW-1:0] idx;
  logic          qinf;
`ifdef SCALAR_CONST_TIME_EN
  logic          discard;
`endif

  // Sequencer: bit walk, operation issue and result capture.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      k_r        <= '0;
      idx        <= '0;
      qinf       <= 1'b0;
      op_start   <= 1'b0;
      op_dbl     <= 1'b0;
      op_p       <= '0;
      op_x1      <= '0;
      op_y1      <= '0;
      op_x2      <= '0;
      op_y2      <= '0;
      x_out      <= '0;
      y_out      <= '0;
      result_inf <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
`ifdef SCALAR_CONST_TIME_EN
      discard    <= 1'b0;
`endif
    end else begin
      op_start <= 1'b0;
      done     <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            k_r   <= k;
            op_p  <= p;
            op_x2 <= xp;
            op_y2 <= yp;
            idx   <= IW'(KW - 1);
            qinf  <= 1'b1;
            busy  <= 1'b1;
            state <= S_SCAN;
          end
        end
        S_SCAN: begin
          if (k_r[idx]) begin
            op_x1 <= op_x2;
            op_y1 <= op_y2;
            qinf  <= 1'b0;
            state <= S_NEXT;
          end else if (idx == '0) begin
            qinf  <= 1'b1;
            state <= S_DONE;
          end else begin
            idx <= idx - IW'(1);
          end
        end
        S_NEXT: begin
          if (idx == '0) begin
            state <= S_DONE;
          end else begin
            idx   <= idx - IW'(1);
            state <= S_DBL;
          end
        end
        S_DBL: begin
          if (qinf) begin
            state <= S_BITCHK;
          end else begin
            op_start <= 1'b1;
            op_dbl   <= 1'b1;
            state    <= S_DBL_WAIT;
          end
        end
        S_DBL_WAIT: begin
          if (op_done) begin
            op_x1 <= op_x3;
            op_y1 <= op_y3;
            qinf  <= op_inf;
            state <= S_BITCHK;
          end
        end
        S_BITCHK: begin
          if (!k_r[idx]) begin
`ifdef SCALAR_CONST_TIME_EN
            // dummy add keeps the per-bit op pattern independent of k
            op_start <= 1'b1;
            op_dbl   <= 1'b0;
            discard  <= 1'b1;
            state    <= S_ADD_WAIT;
`else
            state <= S_NEXT;
`endif
          end else if (qinf) begin
            op_x1 <= op_x2;
            op_y1 <= op_y2;
            qinf  <= 1'b0;
            state <= S_NEXT;
          end else begin
            // Q.x == P.x is not special-cased: the unit reports infinity
            op_start <= 1'b1;
            op_dbl   <= 1'b0;
`ifdef SCALAR_CONST_TIME_EN
            discard  <= 1'b0;
`endif
            state    <= S_ADD_WAIT;
          end
        end
        S_ADD_WAIT: begin
          if (op_done) begin
`ifdef SCALAR_CONST_TIME_EN
            if (!discard) begin
              op_x1 <= op_x3;
              op_y1 <= op_y3;
              qinf  <= op_inf;
            end
`else
            op_x1 <= op_x3;
            op_y1 <= op_y3;
            qinf  <= op_inf;
`endif
            state <= S_NEXT;
          end
        end
        S_DONE: begin
          x_out      <= qinf ? '0 : op_x1;
          y_out      <= qinf ? '0 : op_y1;
          result_inf <= qinf;
          done       <= 1'b1;
          busy       <= 1'b0;
          state      <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_scalar_mult_ctrl.sv
// Bench for scalar_mult_ctrl on curve y^2 = x^3 + 2x + 2 over GF(17), P = (5,1).
// A behavioural point unit answers each op after a random 3-20 cycle delay.
// Expected op sequences and results are queued before each start; monitors
// pop and compare whenever the DUT pulses op_start or done.
module tb_scalar_mult_ctrl;
  localparam int N  = 8;
  localparam int KW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [KW-1:0] k_in;
  logic [N-1:0]  p_in, xp_in, yp_in;
  logic          op_start, op_dbl;
  logic [N-1:0]  op_p, op_x1, op_y1, op_x2, op_y2;
  logic          op_done;
  logic [N-1:0]  op_x3, op_y3;
  logic          op_inf;
  logic [N-1:0]  x_out, y_out;
  logic          result_inf, busy, done;

  typedef struct packed {
    logic [N-1:0] x;
    logic [N-1:0] y;
    logic         inf;
  } res_t;

  bit   exp_ops[$];
  res_t exp_res[$];
  int   checks = 0;
  int   errors = 0;
  int   n_ops  = 0;
  int   n_done = 0;
  bit   model_busy = 1'b0;

  scalar_mult_ctrl #(.n(N), .KW(KW)) dut (
    .clk(clk), .reset(reset), .start(start), .k(k_in), .p(p_in),
    .xp(xp_in), .yp(yp_in), .op_start(op_start), .op_dbl(op_dbl),
    .op_p(op_p), .op_x1(op_x1), .op_y1(op_y1), .op_x2(op_x2), .op_y2(op_y2),
    .op_done(op_done), .op_x3(op_x3), .op_y3(op_y3), .op_inf(op_inf),
    .x_out(x_out), .y_out(y_out), .result_inf(result_inf),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, act, expv);
    end
  endtask

  function automatic int md(input int a, input int m);
    return ((a % m) + m) % m;
  endfunction

  function automatic int inv(input int a, input int m);
    for (int i = 1; i < m; i++)
      if (md(a * i, m) == 1) return i;
    return 0;
  endfunction

  function automatic void ec_op(input int x1, input int y1, input int x2, input int y2,
                                input int m, input bit dbl,
                                output int x3, output int y3, output bit inf);
    int lam, xo;
    inf = 1'b0; x3 = 0; y3 = 0;
    xo = dbl ? x1 : x2;
    if (!dbl && x1 != x2) begin
      lam = md((y2 - y1) * inv(md(x2 - x1, m), m), m);
    end else if (!dbl && md(y1 + y2, m) == 0) begin
      inf = 1'b1; return;
    end else if (y1 == 0) begin
      inf = 1'b1; return;
    end else begin
      lam = md((3 * x1 * x1 + 2) * inv(md(2 * y1, m), m), m);
    end
    x3 = md(lam * lam - x1 - xo, m);
    y3 = md(lam * (x1 - x3) - y1, m);
  endfunction

  // behavioural point unit
  initial begin
    int x3, y3, lat, extra;
    bit inf, aborted;
    logic [5*N:0] snap;
    op_done = 1'b0; op_x3 = '0; op_y3 = '0; op_inf = 1'b0;
    forever begin
      @(negedge clk);
      if (op_start && !reset) begin
        model_busy = 1'b1;
        aborted = 1'b0;
        extra = 0;
        snap = {op_dbl, op_p, op_x1, op_y1, op_x2, op_y2};
        chk("op_base_p", {op_p, op_x2, op_y2}, {8'd17, 8'd5, 8'd1});
        ec_op(int'(op_x1), int'(op_y1), int'(op_x2), int'(op_y2), int'(op_p), op_dbl, x3, y3, inf);
        lat = $urandom_range(3, 20);
        repeat (lat) begin
          @(negedge clk);
          if (reset) aborted = 1'b1;
          if (op_start) extra++;
        end
        if (!aborted) begin
          chk("op_stable", {op_dbl, op_p, op_x1, op_y1, op_x2, op_y2}, snap);
          chk("op_single_flight", extra, 0);
        end
        op_x3 = N'(x3); op_y3 = N'(y3); op_inf = inf; op_done = 1'b1;
        @(negedge clk);
        op_done = 1'b0;
        model_busy = 1'b0;
      end
    end
  end

  // op monitor
  always @(negedge clk) begin
    if (op_start) begin
      n_ops++;
      if (exp_ops.size() == 0) chk("op_unexpected", 1, 0);
      else chk("op_kind", op_dbl, exp_ops.pop_front());
    end
  end

  // result monitor
  always @(negedge clk) begin
    if (done) begin
      n_done++;
      if (exp_res.size() == 0) chk("done_unexpected", 1, 0);
      else chk("result", {x_out, y_out, result_inf}, exp_res.pop_front());
    end
  end

  task automatic push_ops(input string s);
    for (int i = 0; i < s.len(); i++) exp_ops.push_back(s[i] == "d");
  endtask

  task automatic run(input logic [KW-1:0] kv, input string ops,
                     input int ex, input int ey, input bit einf,
                     input bit poke, input int exp_lat);
    int cyc, ops0, done0;
    bit got;
    res_t r;
    ops0 = n_ops; done0 = n_done;
    push_ops(ops);
    r.x = N'(ex); r.y = N'(ey); r.inf = einf;
    exp_res.push_back(r);
    @(negedge clk);
    k_in = kv; start = 1'b1;
    cyc = 0; got = 1'b0;
    while (cyc < 3000 && !got) begin
      @(negedge clk);
      cyc++;
      if (poke && cyc == 4) begin k_in = 8'd1; start = 1'b1; end
      else start = 1'b0;
      if (cyc == 1) chk("busy_after_start", busy, 1);
      if (done) got = 1'b1;
    end
    chk("done_timeout", got, 1);
    if (exp_lat > 0) chk("latency", cyc, exp_lat);
    repeat (3) @(negedge clk);
    chk("op_count", n_ops - ops0, ops.len());
    chk("done_once", n_done - done0, 1);
    chk("busy_after_done", busy, 0);
  endtask

  initial begin
    int c, ops0, done0;
    reset = 1'b1; start = 1'b0; k_in = '0;
    p_in = 8'd17; xp_in = 8'd5; yp_in = 8'd1;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_outputs", {op_start, op_dbl, op_p, op_x1, op_y1, op_x2, op_y2,
                          x_out, y_out, result_inf, busy, done}, 64'd0);
    @(negedge clk);
    reset = 1'b0;

`ifdef SCALAR_CONST_TIME_EN
    run(8'd5,  "dada",     9, 16, 1'b0, 1'b0, 0);
    run(8'd19, "dadadada", 0,  0, 1'b1, 1'b1, 0);
`else
    run(8'd5,  "dda",      9, 16, 1'b0, 1'b0, 0);
    run(8'd19, "dddada",   0,  0, 1'b1, 1'b1, 0);
`endif
    run(8'd0, "", 0, 0, 1'b1, 1'b0, KW + 2);
    run(8'd1, "", 5, 1, 1'b0, 1'b0, 0);
`ifdef SCALAR_CONST_TIME_EN
    run(8'd2, "da", 6, 3, 1'b0, 1'b0, 0);
`else
    run(8'd2, "d",  6, 3, 1'b0, 1'b0, 0);
`endif

    // abort during the first doubling of k=5
    ops0 = n_ops; done0 = n_done;
    push_ops("d");
    @(negedge clk);
    k_in = 8'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    c = 0;
    while (!model_busy && c < 100) begin @(negedge clk); c++; end
    chk("abort_op_seen", model_busy, 1);
    reset = 1'b1;
    #1;
    chk("abort_outputs", {op_start, op_dbl, op_p, op_x1, op_y1, op_x2, op_y2,
                          x_out, y_out, result_inf, busy, done}, 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    c = 0;
    while (model_busy && c < 100) begin @(negedge clk); c++; end
    chk("stray_done_sent", model_busy, 0);
    repeat (5) @(negedge clk);
    chk("stray_no_done", n_done - done0, 0);
    chk("stray_no_ops", n_ops - ops0, 1);
    chk("stray_idle", busy, 0);

    run(8'd3, "da", 10, 6, 1'b0, 1'b0, 0);
`ifdef SCALAR_CONST_TIME_EN
    run(8'd4, "dada", 3, 1, 1'b0, 1'b0, 0);
`else
    run(8'd4, "dd",   3, 1, 1'b0, 1'b0, 0);
`endif

    chk("ops_queue_empty", exp_ops.size(), 0);
    chk("res_queue_empty", exp_res.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got 1 want 0");
    $fatal(1, "timeout");
  end
endmodule
